my_div_seq: RTL and testbench

// - Iterative restoring divider; the inverse operation of the combinational

---
 rtl/my_div_seq.sv | 138 +++++++++++++
 tb/tb_my_div_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/my_div_seq.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional two's-complement mode when MY_DIV_SIGNED_EN is defined.
module my_div_seq #(
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [BITWIDTH-1:0] ain,
    input  logic [BITWIDTH-1:0] bin,
    output logic [BITWIDTH-1:0] dout,
    output logic [BITWIDTH-1:0] rem,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero,
    output logic                overflow
);
    // state | meaning
    // IDLE  | waiting for start
    // CALC  | one quotient bit per cycle; final cycle writes the result
    // DONE  | done pulse, result valid; start here begins the next divide
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = $clog2(BITWIDTH + 1);

    state_t              state, state_nxt;
    logic [CW-1:0]       count;
    logic [BITWIDTH-1:0] part;
    logic [BITWIDTH-1:0] quo;
    logic [BITWIDTH-1:0] dvs;
    logic                zero_pend;
    logic [BITWIDTH-1:0] a_mag, b_mag;
    logic [BITWIDTH:0]   trial;
    logic                accept, last;

    assign accept = start && (state != CALC);
    assign last   = (state == CALC) && (count == CW'(BITWIDTH));
    assign trial  = {part, quo[BITWIDTH-1]} - {1'b0, dvs};

`ifdef MY_DIV_SIGNED_EN
    localparam logic [BITWIDTH-1:0] MIN_INT = {1'b1, {(BITWIDTH-1){1'b0}}};
    logic a_neg, b_neg, neg_q, neg_r, ovf_pend;

    always_comb begin
        a_neg = ain[BITWIDTH-1];
        b_neg = bin[BITWIDTH-1];
        a_mag = a_neg ? -ain : ain;
        b_mag = b_neg ? -bin : bin;
    end
`else
    always_comb begin
        a_mag = ain;
        b_mag = bin;
    end
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? CALC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A zero divisor skips the iterations by presetting the counter to its
    // terminal value, so it finishes one cycle after capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            part        <= '0;
            quo         <= '0;
            dvs         <= '0;
            zero_pend   <= 1'b0;
            dout        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
`ifdef MY_DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            ovf_pend    <= 1'b0;
            overflow    <= 1'b0;
`endif
        end else if (accept) begin
            part        <= '0;
            dvs         <= b_mag;
            zero_pend   <= (bin == '0);
            count       <= (bin == '0) ? CW'(BITWIDTH) : '0;
            quo         <= (bin == '0) ? ain : a_mag;
            div_by_zero <= 1'b0;
`ifdef MY_DIV_SIGNED_EN
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            ovf_pend    <= (ain == MIN_INT) && (bin == '1);
            overflow    <= 1'b0;
`endif
        end else if (state == CALC) begin
            if (!last) begin
                count <= count + CW'(1);
                if (!trial[BITWIDTH]) begin
                    part <= trial[BITWIDTH-1:0];
                    quo  <= {quo[BITWIDTH-2:0], 1'b1};
                end else begin
                    part <= {part[BITWIDTH-2:0], quo[BITWIDTH-1]};
                    quo  <= {quo[BITWIDTH-2:0], 1'b0};
                end
            end else if (zero_pend) begin
                dout        <= '1;
                rem         <= quo;
                div_by_zero <= 1'b1;
            end else begin
`ifdef MY_DIV_SIGNED_EN
                dout     <= neg_q ? -quo : quo;
                rem      <= neg_r ? -part : part;
                overflow <= ovf_pend;
`else
                dout     <= quo;
                rem      <= part;
`endif
            end
        end
    end
endmodule

// File: tb/tb_my_div_seq.sv
// Directed and random checks of my_div_seq: latency, results, flags, handshake, reset abort.
module tb_my_div_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] ain, bin;
    logic [31:0] dout, rem;
    logic        busy, done, div_by_zero, overflow;

    int errors = 0;
    int checks = 0;

    my_div_seq #(.BITWIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ain(ain), .bin(bin),
        .dout(dout), .rem(rem), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after an edge; the next rising edge is the capture edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic long_op);
        start = 1'b1; ain = a; bin = b;
        @(posedge clk); #1;
        start = 1'b0; ain = 32'hdead_beef; bin = 32'h0bad_f00d;
        chk("flag_clear", div_by_zero, 1'b0);
        if (long_op) chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic check_res(input string tag, input logic [31:0] q, input logic [31:0] r,
                             input logic dz, input logic ov);
        chk({tag, "_dout"}, dout, q);
        chk({tag, "_rem"}, rem, r);
        chk({tag, "_dbz"}, div_by_zero, dz);
        chk({tag, "_ovf"}, overflow, ov);
    endtask

    task automatic div(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic dz, input logic ov);
        issue(a, b, b != 0);
        wait_done(tag, (b == 0) ? 1 : 33);
        check_res(tag, q, r, dz, ov);
    endtask

    initial begin
        logic [31:0] ra, rb, eq, er;
        int seen;
        reset_n = 1'b0; start = 1'b0; ain = '0; bin = '0;
        repeat (3) @(posedge clk);
        #1;
        check_res("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
        chk("dout_held", dout, 32'd14);

        div("max_1", 32'hffff_ffff, 32'h1, 32'hffff_ffff, 32'h0, 1'b0, 1'b0);
        div("d5_9", 32'h5, 32'h9, 32'h0, 32'h5, 1'b0, 1'b0);
        div("d5_0", 32'h5, 32'h0, 32'hffff_ffff, 32'h5, 1'b1, 1'b0);
        div("d37_37", 32'd37, 32'd37, 32'd1, 32'd0, 1'b0, 1'b0);

        // start with new operands part way through must not disturb the divide
        issue(32'd1000, 32'd10, 1'b1);
        repeat (9) @(posedge clk);
        #1; start = 1'b1; ain = 32'd7; bin = 32'd1;
        @(posedge clk); #1; start = 1'b0;
        seen = -1;
        for (int k = 11; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) begin seen = k; break; end
        end
        chk("ignored_latency", seen, 33);
        check_res("ignored", 32'd100, 32'd0, 1'b0, 1'b0);

        // reset mid-divide aborts with no done pulse
        issue(32'd999, 32'd4, 1'b1);
        repeat (20) @(posedge clk);
        #1; reset_n = 1'b0; #1;
        check_res("abort", 32'h0, 32'h0, 1'b0, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(negedge clk); reset_n = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        chk("abort_no_done", seen, 0);

        // back-to-back: start held during the done cycle
        issue(32'd200, 32'd3, 1'b1);
        wait_done("b2b_first", 33);
        check_res("b2b_first", 32'd66, 32'd2, 1'b0, 1'b0);
        issue(32'd50, 32'd5, 1'b1);
        wait_done("b2b_second", 33);
        check_res("b2b_second", 32'd10, 32'd0, 1'b0, 1'b0);

`ifdef MY_DIV_SIGNED_EN
        div("s_m7_2", 32'hffff_fff9, 32'd2, 32'hffff_fffd, 32'hffff_ffff, 1'b0, 1'b0);
        div("s_7_m2", 32'd7, 32'hffff_fffe, 32'hffff_fffd, 32'd1, 1'b0, 1'b0);
        div("s_min_m1", 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 32'h0, 1'b0, 1'b1);
        div("s_m5_0", 32'hffff_fffb, 32'h0, 32'hffff_ffff, 32'hffff_fffb, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'h0) rb = 32'd3;
            if (rb == 32'hffff_ffff) rb = 32'd7;
`ifdef MY_DIV_SIGNED_EN
            eq = $signed(ra) / $signed(rb);
            er = $signed(ra) % $signed(rb);
`else
            eq = ra / rb;
            er = ra % rb;
`endif
            $display("random %0d: %h / %h -> q=%h r=%h", i, ra, rb, eq, er);
            div($sformatf("rand%0d", i), ra, rb, eq, er, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
